// File: rtl/stream_arith_pipeline_if.sv
// Stream bundle for stream_arith_pipeline: operand input side and result output side.
// master = producer/consumer environment, slave = the pipeline.
interface stream_arith_pipeline_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic [DATA_WIDTH-1:0] in_c;
    logic                  in_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_result;
    logic                  out_overflow;

    modport master (
        output in_valid, in_a, in_b, in_c, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_op, out_ready,
        output in_ready, out_valid, out_result, out_overflow
    );
endinterface

// File: rtl/stream_arith_pipeline.sv
// 4-stage valid/ready pipeline: result = (a+b or |a-b|) * c, saturate or truncate.
// Stages: S1 operands, S2 sum/absdiff, S3 full product, S4 output register.
module stream_arith_pipeline #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    stream_arith_pipeline_if.slave      bus,
    output logic [2:0]                  occupancy
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2*DW + 1;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic          op;
    } s1_t;

    typedef struct packed {
        logic [DW:0]   f;
        logic [DW-1:0] c;
    } s2_t;

    logic                 v1, v2, v3, v4;
    logic                 adv1, adv2, adv3, adv4;
    s1_t                  s1;
    s2_t                  s2;
    logic [PW-1:0]        s3_prod;
    logic [OUT_WIDTH-1:0] res_q;
    logic                 ovf_q;

    logic [DW:0]          f_d;
    logic [PW-1:0]        prod_d;
    logic                 ovf_d;
    logic [OUT_WIDTH-1:0] res_d;

    // Each stage may move whenever everything downstream makes room.
    assign adv4 = !v4 || bus.out_ready;
    assign adv3 = !v3 || adv4;
    assign adv2 = !v2 || adv3;
    assign adv1 = !v1 || adv2;

    assign bus.in_ready     = adv1 && !flush;
    assign bus.out_valid    = v4;
    assign bus.out_result   = res_q;
    assign bus.out_overflow = ovf_q;

    assign occupancy = 3'(v1) + 3'(v2) + 3'(v3) + 3'(v4);

    always_comb begin
        f_d = '0;
        unique case (1'b1)
            s1.op && (s1.a >= s1.b): f_d = {1'b0, s1.a - s1.b};
            s1.op && (s1.a <  s1.b): f_d = {1'b0, s1.b - s1.a};
            default:                 f_d = {1'b0, s1.a} + {1'b0, s1.b};
        endcase
    end

    assign prod_d = PW'(s2.f) * PW'(s2.c);

    generate
        if (OUT_WIDTH < PW) begin : g_ovf
            assign ovf_d = |s3_prod[PW-1:OUT_WIDTH];
        end else begin : g_no_ovf
            assign ovf_d = 1'b0;
        end
    endgenerate

    assign res_d = (SATURATE && ovf_d) ? '1 : s3_prod[OUT_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else begin
            if (adv1) v1 <= bus.in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
            if (adv4) v4 <= v3;
        end
    end

    // Data only moves with a valid sample, so a stalled S4 holds its value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            s3_prod <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready)
                s1 <= '{a: bus.in_a, b: bus.in_b, c: bus.in_c, op: bus.in_op};
            if (adv2 && v1)
                s2 <= '{f: f_d, c: s1.c};
            if (adv3 && v2)
                s3_prod <= prod_d;
            if (adv4 && v3) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_stream_arith_pipeline.sv
// Scoreboard bench for stream_arith_pipeline: directed plan plus random traffic
// with random backpressure, checked against a plain-arithmetic reference model.
module tb_stream_arith_pipeline;
    localparam int DW  = 8;
    localparam int OW  = 2*DW;
    localparam bit SAT = 1'b1;

    typedef struct packed {
        logic [OW-1:0] res;
        logic          ovf;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic [2:0] occupancy;

    stream_arith_pipeline_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

    stream_arith_pipeline #(
        .DATA_WIDTH(DW),
        .OUT_WIDTH (OW),
        .SATURATE  (SAT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .bus      (bus),
        .occupancy(occupancy)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    bit   prev_stall  = 0;
    exp_t prev_out;
    bit   rnd_done    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: unsigned arithmetic at full precision, then clamp/truncate.
    function automatic exp_t model(int unsigned a, int unsigned b,
                                   int unsigned c, bit op);
        longint unsigned f, full, maxv;
        exp_t e;
        f    = op ? ((a >= b) ? a - b : b - a) : a + b;
        full = f * c;
        maxv = (64'd1 << OW) - 1;
        e.ovf = full > maxv;
        if (e.ovf && SAT) e.res = OW'(maxv);
        else              e.res = OW'(full & maxv);
        return e;
    endfunction

    // Monitor: observes both ports away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("in_ready", 64'(bus.in_ready),
                64'(!flush && (exp_q.size() < 4 || bus.out_ready)));
            if (prev_stall && bus.out_valid) begin
                chk("hold_result", 64'(bus.out_result), 64'(prev_out.res));
                chk("hold_overflow", 64'(bus.out_overflow), 64'(prev_out.ovf));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got result %0d, expected none (t=%0t)",
                             bus.out_result, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 64'(bus.out_result), 64'(e.res));
                    chk("overflow", 64'(bus.out_overflow), 64'(e.ovf));
                end
            end
            prev_stall   = bus.out_valid && !bus.out_ready && !flush;
            prev_out.res = bus.out_result;
            prev_out.ovf = bus.out_overflow;
            if (flush)
                exp_q.delete();
            else if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_c, bus.in_op));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned a, input int unsigned b,
                        input int unsigned c, input bit op);
        bit ok;
        bus.in_a     = DW'(a);
        bus.in_b     = DW'(b);
        bus.in_c     = DW'(c);
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no acceptance, expected one within 100 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // out_valid must appear exactly 3 edges after the acceptance edge.
    task automatic latency_after_send(string name);
        for (int k = 0; k < 4; k++) begin
            chk(name, 64'(bus.out_valid), 64'(k == 3));
            if (k < 3) tick();
        end
    endtask

    function automatic int unsigned rnd_op();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 2) return (1 << DW) - 1;
        if (r < 3) return 0;
        return $urandom_range(0, (1 << DW) - 1);
    endfunction

    int unsigned sa [5] = '{5, 10, 3, 8, 12};
    int unsigned sb [5] = '{3, 2, 7, 4, 1};
    int unsigned sc [5] = '{2, 4, 3, 5, 6};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.in_op     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.out_result), 64'd0);
        chk("rst_overflow", 64'(bus.out_overflow), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Streaming, back to back, with first-output latency
        for (int i = 0; i < 8; i++) begin
            if (i > 0) chk("stream_latency", 64'(bus.out_valid), 64'(i - 1 >= 3));
            if (i < 5) begin
                bus.in_a = DW'(sa[i]);
                bus.in_b = DW'(sb[i]);
                bus.in_c = DW'(sc[i]);
                bus.in_op = 1'b0;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        drain();

        // Op select and overflow corner
        send(3, 7, 3, 1);
        send(7, 3, 3, 1);
        send(9, 9, 5, 1);
        send(255, 255, 255, 0);
        send(255, 0, 255, 1);
        drain();

        // Backpressure: fill with out_ready low, then release
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(20 + i, 3 * i, 7 + i, i[0]);
        bus.in_a = 8'd100; bus.in_b = 8'd50; bus.in_c = 8'd9; bus.in_op = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_occupancy", 64'(occupancy), 64'd4);
        tick();
        bus.out_ready = 1'b1;
        send(100, 50, 9, 1);
        send(200, 100, 250, 0);
        drain();

        // Flush with three samples in flight and a competing input
        send(1, 2, 3, 0);
        send(4, 5, 6, 0);
        send(7, 8, 9, 1);
        flush = 1'b1;
        bus.in_a = 8'd11; bus.in_b = 8'd12; bus.in_c = 8'd13; bus.in_op = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (4) tick();
        send(6, 9, 4, 1);
        latency_after_send("flush_latency");
        drain();

        // Asynchronous reset with two samples in flight
        send(15, 16, 17, 0);
        send(18, 2, 19, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        #3 reset_n = 1'b1;
        tick();
        chk("arst_resume_occ", 64'(occupancy), 64'd0);
        send(30, 40, 50, 0);
        latency_after_send("arst_latency");
        drain();

        // Random traffic with random backpressure
        fork
            while (!rnd_done) begin
                tick();
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_arith_pipeline.md
Name: stream_arith_pipeline

Overview:
- Parametrised 4-stage arithmetic pipeline computing result = f(a,b) * c, where f is selected per sample: sum (a+b) or absolute difference |a-b|.
- Successor to the fixed-width enable-driven pipeline. Adds a valid/ready handshake with full backpressure, per-sample op select, a selectable saturate/truncate output, synchronous flush and an occupancy count.
- Sits between an upstream producer and a downstream consumer in the datapath.

Parameters:
- DATA_WIDTH, 8, width of operands a, b, c (unsigned).
- OUT_WIDTH, 2*DATA_WIDTH, width of out_result; must be <= 2*DATA_WIDTH+1.
- SATURATE, 1, 1 = clamp result to 2^OUT_WIDTH-1 on overflow; 0 = keep the low OUT_WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight samples.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_a  in  DATA_WIDTH  operand a.
- in_b  in  DATA_WIDTH  operand b.
- in_c  in  DATA_WIDTH  multiplier c.
- in_op  in  1  0 = (a+b)*c; 1 = |a-b|*c.
- out_valid  out  1  out_result holds a sample.
- out_ready  in  1  downstream accepts the sample.
- out_result  out  OUT_WIDTH  result.
- out_overflow  out  1  full-precision result exceeded 2^OUT_WIDTH-1; qualified by out_valid.
- occupancy  out  3  number of valid stages, 0..4.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: all stage valid bits 0, out_valid=0, out_result=0, out_overflow=0, occupancy=0, in_ready=1 once reset is released. Reset asserted mid-operation drops every in-flight sample immediately, with no output.
- Stages, each with a valid bit:
  - S1: registers a, b, c, op.
  - S2: computes DATA_WIDTH+1-bit sum or absolute difference; carries c.
  - S3: computes (2*DATA_WIDTH+1)-bit full product.
  - S4: output register. Applies saturate or truncate, computes overflow.
- Advance rule:
  - adv4 = !v4 || out_ready.
  - advK = !vK || adv(K+1) for K = 3..1.
  - in_ready = adv1 && !flush.
  - A stage loads from its predecessor when it advances. If it advances and the predecessor is empty, its valid bit clears. A stalled stage holds data and valid.
  - in_ready depends combinationally on out_ready. Accepted cost of full throughput with no bubbles.
- Transfers: input transfer on a rising edge with in_valid && in_ready; output transfer on a rising edge with out_valid && out_ready.
- Latency: a sample accepted at edge N is in S4 (out_valid=1) after edge N+3 if there is no stall. Throughput is 1 sample/cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, the pipeline fills. in_ready falls once all 4 stages are valid.
  - out_result and out_overflow stay stable while out_valid && !out_ready.
- Ordering: samples exit in acceptance order; none are dropped or duplicated.
- Arithmetic: all unsigned. |a-b| = a>=b ? a-b : b-a. Full product has no internal truncation.
- overflow = full product > 2^OUT_WIDTH-1. When OUT_WIDTH = 2*DATA_WIDTH+1, overflow is always 0.
- Flush:
  - Flush high at a rising edge clears all valid bits; occupancy=0 next cycle.
  - Flush wins over a simultaneous input transfer: in_ready=0 while flush is high, so no sample is accepted.
  - A simultaneous output transfer still completes.
- occupancy = v1+v2+v3+v4, from registered valid bits.

Test Plan:
- Streaming: reset, out_ready=1, feed (a,b,c,op) = (5,3,2,0), (10,2,4,0), (3,7,3,0), (8,4,5,0), (12,1,6,0) back-to-back -> out_valid first seen after the 4th edge from the first acceptance; results 16, 48, 30, 60, 78 on consecutive cycles; overflow=0.
- Op select: (3,7,3,1) -> 12; (7,3,3,1) -> 12; (9,9,5,1) -> 0.
- Overflow, defaults: (255,255,255,0) -> full product 130050; SATURATE=1 gives 65535 with overflow=1; SATURATE=0 gives 64514 with overflow=1.
- Backpressure: stream 6 samples with out_ready=0 -> in_ready low after 4 accepted, occupancy=4, out_result stable. Release out_ready -> all 6 results in order, no loss.
- Flush: 3 samples in flight, pulse flush together with in_valid=1 -> in_ready=0 that cycle, occupancy 0 next cycle, no out_valid for flushed samples; the next accepted sample returns correctly after 4 edges.
- Reset mid-stream: assert reset_n=0 asynchronously between edges with 2 samples in flight -> out_valid=0 and occupancy=0 immediately; after release, normal operation resumes.
